// File: rtl/viterbi_pkg.sv
// Shared definitions for the Viterbi decoder datapath.
//   ACS_PM_W / ACS_BM_W : default path-metric and branch-metric widths.
//   PM_MAX              : largest path metric at the default width.
//   acs_result_t        : one ACS output, survivor decision bit plus path metric.
//   pm_max_of()         : largest representable path metric for a given width.
package viterbi_pkg;

    localparam int ACS_PM_W = 8;
    localparam int ACS_BM_W = 3;

    localparam int PM_MAX = (1 << ACS_PM_W) - 1;

    typedef struct packed {
        logic                dec;
        logic [ACS_PM_W-1:0] pm;
    } acs_result_t;

    function automatic int pm_max_of(input int width);
        return (1 << width) - 1;
    endfunction

endpackage

// File: rtl/sat_add.sv
// Saturating adder: a (PM_W bits) plus zero-extended b (BM_W bits).
//   a   : path metric
//   b   : branch metric
//   sum : a + b, clamped to 2^PM_W - 1
//   sat : 1 when the clamp was applied
// Purely combinational.
module sat_add #(
    parameter int PM_W = 8,
    parameter int BM_W = 3
) (
    input  logic [PM_W-1:0] a,
    input  logic [BM_W-1:0] b,
    output logic [PM_W-1:0] sum,
    output logic            sat
);

    logic [PM_W:0] sum_ext;

    // One extra bit holds the carry; a carry out means the sum overflowed.
    assign sum_ext = {1'b0, a} + {{(PM_W + 1 - BM_W){1'b0}}, b};
    assign sat     = sum_ext[PM_W];
    assign sum     = sat ? {PM_W{1'b1}} : sum_ext[PM_W-1:0];

endmodule

// File: rtl/acs_pipe.sv
// Two-stage pipelined add-compare-select unit, one per trellis state.
//   Stage 1: two saturating adds (pm0+bm0, pm1+bm1); captures norm controls.
//   Stage 2: compare/select the smaller sum, optional floored normalisation.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   in_valid/in_ready        : operand handshake (pm0, pm1, bm0, bm1, norm_en, norm_val)
//   out_valid/out_ready      : result handshake (pm_out, dec)
//   sat_flag / sat_clr       : sticky saturation indicator and its clear
//   dec_cnt                  : results delivered, modulo 2^16
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. in_ready does not depend on in_valid; out_valid does not depend on
// out_ready. While out_valid=1 and out_ready=0, pm_out and dec hold steady.
import viterbi_pkg::*;

module acs_pipe #(
    parameter int PM_W    = ACS_PM_W,
    parameter int BM_W    = ACS_BM_W,
    parameter int NORM_EN = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [PM_W-1:0] pm0,
    input  logic [PM_W-1:0] pm1,
    input  logic [BM_W-1:0] bm0,
    input  logic [BM_W-1:0] bm1,
    input  logic            norm_en,
    input  logic [PM_W-1:0] norm_val,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PM_W-1:0] pm_out,
    output logic            dec,
    output logic            sat_flag,
    input  logic            sat_clr,
    output logic [15:0]     dec_cnt
);

    logic [PM_W-1:0] s0_d, s1_d;
    logic            sat0_d, sat1_d;

    logic            v1;
    logic [PM_W-1:0] s0_q, s1_q;
    logic            sat_q;
    logic            norm_q;
    logic [PM_W-1:0] normv_q;

    logic            advance;
    logic            dec_d;
    logic [PM_W-1:0] min_d, pm_d;

    sat_add #(.PM_W(PM_W), .BM_W(BM_W)) u_add0 (.a(pm0), .b(bm0), .sum(s0_d), .sat(sat0_d));
    sat_add #(.PM_W(PM_W), .BM_W(BM_W)) u_add1 (.a(pm1), .b(bm1), .sum(s1_d), .sat(sat1_d));

    // Stage 2 may load whenever it is empty or its result is leaving.
    // Stage 1 may load whenever it is empty or it is moving into stage 2.
    assign advance  = !out_valid | out_ready;
    assign in_ready = !v1 | advance;

    always_comb begin
        dec_d = (s1_q < s0_q);
        min_d = dec_d ? s1_q : s0_q;
        pm_d  = min_d;
        if (NORM_EN != 0 && norm_q) begin
            pm_d = (min_d > normv_q) ? (min_d - normv_q) : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1      <= 1'b0;
            s0_q    <= '0;
            s1_q    <= '0;
            sat_q   <= 1'b0;
            norm_q  <= 1'b0;
            normv_q <= '0;
        end else if (in_ready) begin
            v1 <= in_valid;
            if (in_valid) begin
                s0_q    <= s0_d;
                s1_q    <= s1_d;
                sat_q   <= sat0_d | sat1_d;
                norm_q  <= norm_en;
                normv_q <= norm_val;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            pm_out    <= '0;
            dec       <= 1'b0;
        end else if (advance) begin
            // A bubble in stage 1 clears out_valid but leaves the data as is.
            out_valid <= v1;
            if (v1) begin
                pm_out <= pm_d;
                dec    <= dec_d;
            end
        end
    end

    // Set has priority over clear so a saturation is never lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            sat_flag <= 1'b0;
        end else if (advance && v1 && sat_q) begin
            sat_flag <= 1'b1;
        end else if (sat_clr) begin
            sat_flag <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dec_cnt <= '0;
        end else if (out_valid && out_ready) begin
            dec_cnt <= dec_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_acs_pipe.sv
// Self-checking bench for acs_pipe at PM_W=8, BM_W=3, NORM_EN=1.
module tb_acs_pipe;

  localparam int PM_W = 8;
  localparam int BM_W = 3;
  localparam int PMAX = (1 << PM_W) - 1;
  localparam int NSET = 160;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic            in_valid, in_ready, norm_en, out_valid, out_ready;
  logic [PM_W-1:0] pm0, pm1, norm_val, pm_out;
  logic [BM_W-1:0] bm0, bm1;
  logic            dec, sat_flag, sat_clr;
  logic [15:0]     dec_cnt;

  acs_pipe #(.PM_W(PM_W), .BM_W(BM_W), .NORM_EN(1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .pm0(pm0), .pm1(pm1), .bm0(bm0), .bm1(bm1),
    .norm_en(norm_en), .norm_val(norm_val),
    .out_valid(out_valid), .out_ready(out_ready),
    .pm_out(pm_out), .dec(dec),
    .sat_flag(sat_flag), .sat_clr(sat_clr),
    .dec_cnt(dec_cnt)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [PM_W:0] exp_q[$];   // {dec, pm}
  int st_p0[NSET], st_b0[NSET], st_p1[NSET], st_b1[NSET], st_nv[NSET];
  bit st_ne[NSET];
  int sent, got;
  bit any_sat;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Reference: the ACS rule written as plain integer arithmetic.
  // Returns {sat, dec, pm}.
  function automatic logic [PM_W+1:0] model(input int p0, input int b0, input int p1,
                                            input int b1, input bit ne, input int nv);
    int a, b, m;
    bit s, d;
    a = p0 + b0;
    b = p1 + b1;
    s = (a > PMAX) || (b > PMAX);
    if (a > PMAX) a = PMAX;
    if (b > PMAX) b = PMAX;
    d = (b < a);
    m = d ? b : a;
    if (ne) m = (m > nv) ? m - nv : 0;
    return {s, d, m[PM_W-1:0]};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 0; pm0 = 0; pm1 = 0; bm0 = 0; bm1 = 0;
    norm_en = 0; norm_val = 0; sat_clr = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    idle_inputs();
    out_ready = 1;
    tick(); tick();
    rst = 0;
    #1;
  endtask

  task automatic set_ops(input int p0, input int b0, input int p1, input int b1,
                         input bit ne, input int nv);
    pm0 = p0[PM_W-1:0]; bm0 = b0[BM_W-1:0];
    pm1 = p1[PM_W-1:0]; bm1 = b1[BM_W-1:0];
    norm_en = ne; norm_val = nv[PM_W-1:0];
  endtask

  // Send one set on an idle pipeline; return after out_valid should rise.
  task automatic send_one(input string tag, input int p0, input int b0, input int p1,
                          input int b1, input bit ne, input int nv);
    set_ops(p0, b0, p1, b1, ne, nv);
    in_valid = 1;
    #1;
    check({tag, "_in_ready"}, in_ready, 1);
    tick();
    in_valid = 0;
    check({tag, "_lat1_out_valid"}, out_valid, 0);
    tick();
    check({tag, "_out_valid"}, out_valid, 1);
  endtask

  // Streams stored sets; ready_mode 0 = out_ready low, 1 = high, 2 = random.
  task automatic pump(input int n, input int budget, input int ready_mode, input bit rand_valid);
    logic [PM_W+1:0] r;
    logic [PM_W:0] e;
    for (int c = 0; c < budget && got < n; c++) begin
      case (ready_mode)
        0: out_ready = 0;
        1: out_ready = 1;
        default: out_ready = ($urandom_range(0, 2) != 0);
      endcase
      if (sent < n) begin
        set_ops(st_p0[sent], st_b0[sent], st_p1[sent], st_b1[sent], st_ne[sent], st_nv[sent]);
        in_valid = rand_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
      end else begin
        in_valid = 0;
      end
      #1;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("stream_pm_out", pm_out, e[PM_W-1:0]);
          check("stream_dec", dec, e[PM_W]);
        end
        got++;
      end
      if (in_valid && in_ready) begin
        r = model(st_p0[sent], st_b0[sent], st_p1[sent], st_b1[sent], st_ne[sent], st_nv[sent]);
        exp_q.push_back(r[PM_W:0]);
        if (r[PM_W+1]) any_sat = 1;
        sent++;
      end
      tick();
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [PM_W-1:0] held;
    logic [PM_W+1:0] r;

    do_reset();
    check("rst_out_valid", out_valid, 0);
    check("rst_pm_out", pm_out, 0);
    check("rst_dec", dec, 0);
    check("rst_sat_flag", sat_flag, 0);
    check("rst_dec_cnt", dec_cnt, 0);
    check("rst_in_ready", in_ready, 1);

    // Basic: s0=13, s1=12 -> pick pm1 path.
    send_one("basic", 10, 3, 12, 0, 0, 0);
    check("basic_pm_out", pm_out, 12);
    check("basic_dec", dec, 1);
    tick();
    check("basic_dec_cnt", dec_cnt, 1);
    check("basic_bubble_out_valid", out_valid, 0);

    // Tie: both sums 25, pm0 path wins.
    send_one("tie", 20, 5, 24, 1, 0, 0);
    check("tie_pm_out", pm_out, 25);
    check("tie_dec", dec, 0);
    check("tie_sat_flag", sat_flag, 0);
    tick();

    // Saturation: both sums clamp to 255.
    send_one("sat", 254, 7, 255, 7, 0, 0);
    check("sat_pm_out", pm_out, 255);
    check("sat_dec", dec, 0);
    check("sat_flag_set", sat_flag, 1);
    tick();
    check("sat_flag_sticky", sat_flag, 1);
    sat_clr = 1;
    tick();
    sat_clr = 0;
    check("sat_flag_clr", sat_flag, 0);

    // Set-wins-over-clear when both land on the same edge.
    set_ops(250, 7, 250, 7, 0, 0);
    in_valid = 1;
    tick();
    in_valid = 0;
    sat_clr = 1;
    tick();
    sat_clr = 0;
    check("sat_set_beats_clr", sat_flag, 1);
    sat_clr = 1; tick(); sat_clr = 0;
    check("sat_flag_clr2", sat_flag, 0);

    // Normalisation: min(102, 91) = 91, minus 50 = 41; minus 200 floors at 0.
    send_one("norm", 100, 2, 90, 1, 1, 50);
    check("norm_pm_out", pm_out, 41);
    check("norm_dec", dec, 1);
    tick();
    send_one("norm_floor", 100, 2, 90, 1, 1, 200);
    check("norm_floor_pm_out", pm_out, 0);
    check("norm_floor_dec", dec, 1);
    check("norm_floor_no_sat", sat_flag, 0);
    tick();

    // Back-pressure: 4 sets with out_ready low, then release.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      st_p0[i] = 10 * i + 5; st_b0[i] = i;
      st_p1[i] = 40 - 7 * i; st_b1[i] = 7 - i;
      st_ne[i] = 0;          st_nv[i] = 0;
    end
    sent = 0; got = 0;
    pump(4, 6, 0, 0);
    check("bp_accepts", sent, 2);
    check("bp_in_ready", in_ready, 0);
    check("bp_out_valid", out_valid, 1);
    r = model(st_p0[0], st_b0[0], st_p1[0], st_b1[0], 0, 0);
    held = r[PM_W-1:0];
    check("bp_pm_out_held", pm_out, held);
    tick(); tick();
    check("bp_pm_out_stable", pm_out, held);
    check("bp_dec_cnt_stalled", dec_cnt, 0);
    pump(4, 40, 1, 0);
    check("bp_all_out", got, 4);
    check("bp_queue_empty", exp_q.size(), 0);
    in_valid = 0;
    #1;
    check("bp_dec_cnt", dec_cnt, 4);

    // Reset mid-operation: the accepted set must never appear.
    do_reset();
    set_ops(30, 1, 40, 2, 0, 0);
    in_valid = 1;
    tick();
    in_valid = 0;
    rst = 1;
    tick();
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      check("rst_mid_out_valid", out_valid, 0);
      tick();
    end
    check("rst_mid_dec_cnt", dec_cnt, 0);
    check("rst_mid_in_ready", in_ready, 1);

    // Random stream with random valid/ready gaps.
    do_reset();
    for (int i = 0; i < NSET; i++) begin
      st_p0[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(PMAX - 8, PMAX) : $urandom_range(0, PMAX);
      st_p1[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(PMAX - 8, PMAX) : $urandom_range(0, PMAX);
      st_b0[i] = $urandom_range(0, (1 << BM_W) - 1);
      st_b1[i] = $urandom_range(0, (1 << BM_W) - 1);
      st_ne[i] = $urandom_range(0, 1);
      st_nv[i] = $urandom_range(0, PMAX);
    end
    sent = 0; got = 0; any_sat = 0;
    exp_q.delete();
    pump(NSET, 3000, 2, 1);
    in_valid = 0;
    out_ready = 1;
    #1;
    check("rand_all_out", got, NSET);
    check("rand_queue_empty", exp_q.size(), 0);
    check("rand_dec_cnt", dec_cnt, NSET);
    check("rand_sat_flag", sat_flag, any_sat);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
